// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encodings and BCD helpers for the clock timebase
package clock_pkg;

   localparam logic [1:0] MODE_RUN     = 2'b00;
   localparam logic [1:0] MODE_SET_MIN = 2'b01;
   localparam logic [1:0] MODE_SET_HR  = 2'b10;

   localparam logic [7:0] BCD_MAX59 = 8'h59;

   // Next value of a two-digit BCD counter that runs 00..59; anything at or
   // above 59 folds back to 00 so a corrupted value heals on the next step.
   function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = v[7:4];
      units = v[3:0];
      if (v >= BCD_MAX59 || tens > 4'd5) begin
         return 8'h00;
      end else if (units >= 4'd9) begin
         return {tens + 4'd1, 4'd0};
      end else begin
         return {tens, units + 4'd1};
      end
   endfunction

endpackage

// File: rtl/bcd_mod60.sv
// rtl/bcd_mod60.sv - two-digit BCD modulo-60 counter with clear and enable
module bcd_mod60
   import clock_pkg::*;
(
   input  logic       clkin,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   output logic [7:0] value,
   output logic       wrap
);

   // Carry-out fires on the step that takes 59 back to 00.
   assign wrap = en && (value == BCD_MAX59);

   // Counter register: reset, then clear, then increment.
   always_ff @(posedge clkin) begin
      if (!reset) begin
         value <= 8'h00;
      end else if (clr) begin
         value <= 8'h00;
      end else if (en) begin
         value <= bcd_inc59(value);
      end
   end

endmodule

// File: rtl/min_sec_counter.sv
// rtl/min_sec_counter.sv - 1 Hz timebase with BCD seconds/minutes and time-set FSM
module min_sec_counter
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       set_btn,
   input  logic       inc_btn,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic [1:0] mode,
   output logic       sec_tick,
   output logic       hr_adv
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;
   logic          set_hist;
   logic          inc_hist;
   logic          set_edge;
   logic          inc_edge;
   logic          tick;
   logic          run_tick;
   logic          sec_en;
   logic          sec_clr;
   logic          sec_wrap;
   logic          min_en;
   logic          min_wrap;
   logic          hr_nxt;
   logic [1:0]    mode_nxt;

   assign set_edge = set_btn && !set_hist;
   assign inc_edge = inc_btn && !inc_hist;

   // A mode change on the same edge as a tick swallows the tick.
   assign tick     = (mode == MODE_RUN) && (presc == PRESC_MAX);
   assign run_tick = tick && !set_edge;

   // Leaving RUN for SET_MIN zeroes the seconds.
   assign sec_en  = run_tick;
   assign sec_clr = set_edge && (mode == MODE_RUN);

   // Minutes step on a seconds carry in RUN or on an increment press in SET_MIN.
   assign min_en = (run_tick && sec_wrap) ||
                   ((mode == MODE_SET_MIN) && inc_edge && !set_edge);

   // Hours advance on the 59:59 rollover, or on an increment press in SET_HR.
   assign hr_nxt = (run_tick && min_wrap) ||
                   ((mode == MODE_SET_HR) && inc_edge && !set_edge);

   // Mode sequencing; the unused encoding drops straight back to RUN.
   always_comb begin
      mode_nxt = mode;
      case (mode)
         MODE_RUN:     if (set_edge) mode_nxt = MODE_SET_MIN;
         MODE_SET_MIN: if (set_edge) mode_nxt = MODE_SET_HR;
         MODE_SET_HR:  if (set_edge) mode_nxt = MODE_RUN;
         default:      mode_nxt = MODE_RUN;
      endcase
   end

   // Button history starts at 1 so a button held through reset is not an edge.
   always_ff @(posedge clkin) begin
      if (!reset) begin
         set_hist <= 1'b1;
         inc_hist <= 1'b1;
      end else begin
         set_hist <= set_btn;
         inc_hist <= inc_btn;
      end
   end

   // Prescaler: runs only in RUN, restarts on every mode change.
   always_ff @(posedge clkin) begin
      if (!reset) begin
         presc <= '0;
      end else if (set_edge || mode != MODE_RUN) begin
         presc <= '0;
      end else if (presc == PRESC_MAX) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Mode register and registered pulse outputs.
   always_ff @(posedge clkin) begin
      if (!reset) begin
         mode     <= MODE_RUN;
         sec_tick <= 1'b0;
         hr_adv   <= 1'b0;
      end else begin
         mode     <= mode_nxt;
         sec_tick <= run_tick;
         hr_adv   <= hr_nxt;
      end
   end

   bcd_mod60 u_sec (
      .clkin (clkin),
      .reset (reset),
      .en    (sec_en),
      .clr   (sec_clr),
      .value (sec),
      .wrap  (sec_wrap)
   );

   bcd_mod60 u_min (
      .clkin (clkin),
      .reset (reset),
      .en    (min_en),
      .clr   (1'b0),
      .value (min),
      .wrap  (min_wrap)
   );

endmodule

// File: tb/tb_min_sec_counter.sv
// tb/tb_min_sec_counter.sv - directed vector bench for min_sec_counter
module tb_min_sec_counter;

   logic       clkin = 1'b0;
   logic       reset = 1'b0;
   logic       set_btn = 1'b0;
   logic       inc_btn = 1'b0;
   logic [7:0] sec;
   logic [7:0] min;
   logic [1:0] mode;
   logic       sec_tick;
   logic       hr_adv;

   int compared = 0;
   int mismatched = 0;

   min_sec_counter #(.TICK_DIV(4)) dut (
      .clkin    (clkin),
      .reset    (reset),
      .set_btn  (set_btn),
      .inc_btn  (inc_btn),
      .sec      (sec),
      .min      (min),
      .mode     (mode),
      .sec_tick (sec_tick),
      .hr_adv   (hr_adv)
   );

   always #5 clkin = ~clkin;

   typedef struct {
      logic       s;
      logic       i;
      logic [7:0] sec;
      logic [7:0] min;
      logic [1:0] mode;
      logic       tk;
      logic       hr;
   } vec_t;

   vec_t tbl[34];

   task automatic cyc(input int n);
      repeat (n) @(posedge clkin);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic press_inc();
      inc_btn = 1'b1;
      cyc(1);
      inc_btn = 1'b0;
      cyc(1);
   endtask

   task automatic press_set();
      set_btn = 1'b1;
      cyc(1);
      set_btn = 1'b0;
      cyc(1);
   endtask

   initial begin
      int hr_cnt;
      int consec;
      logic prev_hr;
      logic [7:0] exp_min;

      // Reset release, two ticks, SET_MIN presses, SET_HR press, back to RUN,
      // one full-length second, then a set press coinciding with a tick.
      tbl[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 8'h01, 8'h00, 2'd0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 8'h02, 8'h00, 2'd0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 8'h02, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 8'h00, 8'h01, 2'd1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h01, 2'd1, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 8'h01, 2'd1, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};
      tbl[20] = '{1'b1, 1'b0, 8'h00, 8'h02, 2'd2, 1'b0, 1'b0};
      tbl[21] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd2, 1'b0, 1'b0};
      tbl[22] = '{1'b0, 1'b1, 8'h00, 8'h02, 2'd2, 1'b0, 1'b1};
      tbl[23] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd2, 1'b0, 1'b0};
      tbl[24] = '{1'b1, 1'b0, 8'h00, 8'h02, 2'd0, 1'b0, 1'b0};
      tbl[25] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd0, 1'b0, 1'b0};
      tbl[26] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd0, 1'b0, 1'b0};
      tbl[27] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd0, 1'b0, 1'b0};
      tbl[28] = '{1'b0, 1'b0, 8'h01, 8'h02, 2'd0, 1'b1, 1'b0};
      tbl[29] = '{1'b0, 1'b0, 8'h01, 8'h02, 2'd0, 1'b0, 1'b0};
      tbl[30] = '{1'b0, 1'b0, 8'h01, 8'h02, 2'd0, 1'b0, 1'b0};
      tbl[31] = '{1'b0, 1'b0, 8'h01, 8'h02, 2'd0, 1'b0, 1'b0};
      tbl[32] = '{1'b1, 1'b0, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};
      tbl[33] = '{1'b0, 1'b0, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0};

      // Reset state
      cyc(3);
      chk("rst_sec", sec, 8'h00);
      chk("rst_min", min, 8'h00);
      chk("rst_mode", {6'b0, mode}, 8'h00);
      chk("rst_tick", {7'b0, sec_tick}, 8'h00);
      chk("rst_hr", {7'b0, hr_adv}, 8'h00);
      reset = 1'b1;

      for (int k = 0; k < 34; k++) begin
         set_btn = tbl[k].s;
         inc_btn = tbl[k].i;
         cyc(1);
         chk($sformatf("v%0d_sec", k), sec, tbl[k].sec);
         chk($sformatf("v%0d_min", k), min, tbl[k].min);
         chk($sformatf("v%0d_mode", k), {6'b0, mode}, {6'b0, tbl[k].mode});
         chk($sformatf("v%0d_tick", k), {7'b0, sec_tick}, {7'b0, tbl[k].tk});
         chk($sformatf("v%0d_hr", k), {7'b0, hr_adv}, {7'b0, tbl[k].hr});
      end
      set_btn = 1'b0;
      inc_btn = 1'b0;

      // SET_MIN: step to 58, then wrap 59 -> 00 -> 01 with no hours advance
      repeat (56) press_inc();
      chk("pre58_min", min, 8'h58);
      exp_min = 8'h58;
      for (int k = 0; k < 3; k++) begin
         exp_min = (exp_min == 8'h58) ? 8'h59 : (exp_min == 8'h59) ? 8'h00 : 8'h01;
         inc_btn = 1'b1;
         cyc(1);
         chk($sformatf("wrap%0d_min", k), min, exp_min);
         chk($sformatf("wrap%0d_hr", k), {7'b0, hr_adv}, 8'h00);
         inc_btn = 1'b0;
         cyc(1);
         chk($sformatf("wrap%0d_hr2", k), {7'b0, hr_adv}, 8'h00);
      end
      chk("wrap_mode", {6'b0, mode}, 8'h01);
      repeat (58) press_inc();
      chk("pre59_min", min, 8'h59);

      // Simultaneous set and inc edges: mode change wins
      set_btn = 1'b1;
      inc_btn = 1'b1;
      cyc(1);
      chk("simul_mode", {6'b0, mode}, 8'h02);
      chk("simul_min", min, 8'h59);
      chk("simul_hr", {7'b0, hr_adv}, 8'h00);
      set_btn = 1'b0;
      inc_btn = 1'b0;
      cyc(1);

      // SET_HR: held inc gives one pulse, two more presses give two more
      hr_cnt = 0;
      consec = 0;
      prev_hr = 1'b0;
      inc_btn = 1'b1;
      for (int k = 0; k < 15; k++) begin
         if (k == 10 || k == 12 || k == 14) inc_btn = 1'b0;
         if (k == 11 || k == 13) inc_btn = 1'b1;
         cyc(1);
         if (hr_adv) hr_cnt++;
         if (hr_adv && prev_hr) consec++;
         prev_hr = hr_adv;
      end
      chk("sethr_pulses", 8'(hr_cnt), 8'd3);
      chk("sethr_consec", 8'(consec), 8'd0);
      chk("sethr_min", min, 8'h59);
      chk("sethr_sec", sec, 8'h00);

      // RUN 60 ticks from 59:00 through the hour rollover
      set_btn = 1'b1;
      cyc(1);
      set_btn = 1'b0;
      chk("run_mode", {6'b0, mode}, 8'h00);
      hr_cnt = 0;
      for (int k = 1; k <= 240; k++) begin
         cyc(1);
         if (hr_adv) hr_cnt++;
         if (k == 236) begin
            chk("roll_pre_sec", sec, 8'h59);
            chk("roll_pre_min", min, 8'h59);
         end
      end
      chk("roll_sec", sec, 8'h00);
      chk("roll_min", min, 8'h00);
      chk("roll_hr", {7'b0, hr_adv}, 8'h01);
      chk("roll_tick", {7'b0, sec_tick}, 8'h01);
      chk("roll_hr_cnt", 8'(hr_cnt), 8'd1);
      cyc(1);
      chk("roll_hr_after", {7'b0, hr_adv}, 8'h00);

      // Reset landing on the 59:59 rollover tick with buttons held
      press_set();
      repeat (59) press_inc();
      chk("pre_rst_min", min, 8'h59);
      press_set();
      set_btn = 1'b1;
      cyc(1);
      set_btn = 1'b0;
      for (int k = 1; k <= 239; k++) begin
         if (k == 238) inc_btn = 1'b1;
         cyc(1);
         if (k == 236) chk("pre_rst_sec", sec, 8'h59);
      end
      reset = 1'b0;
      set_btn = 1'b1;
      cyc(1);
      chk("mid_rst_sec", sec, 8'h00);
      chk("mid_rst_min", min, 8'h00);
      chk("mid_rst_mode", {6'b0, mode}, 8'h00);
      chk("mid_rst_tick", {7'b0, sec_tick}, 8'h00);
      chk("mid_rst_hr", {7'b0, hr_adv}, 8'h00);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk($sformatf("held%0d_mode", k), {6'b0, mode}, 8'h00);
         chk($sformatf("held%0d_hr", k), {7'b0, hr_adv}, 8'h00);
         chk($sformatf("held%0d_min", k), min, 8'h00);
      end
      set_btn = 1'b0;
      inc_btn = 1'b0;
      cyc(1);
      chk("release_mode", {6'b0, mode}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
